// File: rtl/answer_pkg.sv
// Shared types and limits for the answering-machine display path.
// Used by the arbiter and the scan-tube display.
package answer_pkg;

    localparam int N_PLAYERS = 4;

    typedef logic [7:0] score_t;
    typedef logic [1:0] player_t;

    localparam score_t SCORE_MAX = 8'd99;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED,
        JUDGE
    } state_t;

    // Widened to 9 bits so the sum cannot wrap before the clamp.
    function automatic score_t score_add_sat(input score_t old, input score_t amt);
        logic [8:0] sum;
        sum = {1'b0, old} + {1'b0, amt};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[7:0];
    endfunction

    function automatic score_t score_sub_floor(input score_t old, input score_t amt);
        return (old < amt) ? '0 : old - amt;
    endfunction

endpackage

// File: rtl/answer_arbiter_if.sv
// Host/button/display bundle of the answer arbiter.
// The master side is the host and buttons; the slave side is the arbiter.
interface answer_arbiter_if;
    import answer_pkg::*;

    logic [N_PLAYERS-1:0] btn;
    logic                 host_start;
    logic                 host_correct;
    logic                 host_wrong;
    player_t              player;
    score_t               score;
    logic                 locked;
    logic                 armed;
    logic                 scan_restart;

    modport master (
        output btn, host_start, host_correct, host_wrong,
        input  player, score, locked, armed, scan_restart
    );

    modport slave (
        input  btn, host_start, host_correct, host_wrong,
        output player, score, locked, armed, scan_restart
    );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector
// for one asynchronous player button.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/answer_arbiter.sv
// Four-button answer arbiter with per-player score bank and registered display outputs.
// Optional feature: define ANSWER_PENALTY_EN to deduct PENALTY points on a wrong answer.
module answer_arbiter
    import answer_pkg::*;
#(
    parameter int AWARD       = 10,
    parameter int PENALTY     = 5,
    parameter int ARM_TIMEOUT = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    answer_arbiter_if.slave bus
);

`ifdef ANSWER_PENALTY_EN
    localparam bit PENALTY_ON = 1'b1;
`else
    localparam bit PENALTY_ON = 1'b0;
`endif

    localparam score_t      AWARD_AMT    = score_t'(AWARD);
    localparam score_t      WRONG_DEDUCT = PENALTY_ON ? score_t'(PENALTY) : '0;
    localparam logic [25:0] TIMER_LAST   = 26'(ARM_TIMEOUT - 1);

    logic [N_PLAYERS-1:0] rise;
    player_t              win_idx;
    score_t               wr_data_d;

    state_t      state_q;
    player_t     player_q;
    score_t      score_q;
    logic        locked_q;
    logic        armed_q;
    logic        scan_restart_q;
    logic        judge_correct_q;
    logic [25:0] timer_q;
    score_t      bank_q [N_PLAYERS];

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_btn
        btn_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (bus.btn[i]),
            .rise (rise[i])
        );
    end

    // Lowest index wins when several buttons rise together.
    always_comb begin
        win_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (rise[i]) win_idx = player_t'(i);
        end
    end

    always_comb begin
        wr_data_d = bank_q[player_q];
        if (judge_correct_q) wr_data_d = score_add_sat(bank_q[player_q], AWARD_AMT);
        else                 wr_data_d = score_sub_floor(bank_q[player_q], WRONG_DEDUCT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            player_q        <= '0;
            locked_q        <= 1'b0;
            armed_q         <= 1'b0;
            scan_restart_q  <= 1'b0;
            judge_correct_q <= 1'b0;
            timer_q         <= '0;
        end else begin
            scan_restart_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.host_start) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                        timer_q <= '0;
                    end
                end
                ARMED: begin
                    if (|rise) begin
                        state_q        <= LOCKED;
                        player_q       <= win_idx;
                        locked_q       <= 1'b1;
                        armed_q        <= 1'b0;
                        scan_restart_q <= 1'b1;
                    end else if (bus.host_start) begin
                        timer_q <= '0;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= IDLE;
                        armed_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 26'd1;
                    end
                end
                LOCKED: begin
                    // Conflicting judgements are dropped; a lone judgement beats an abort.
                    if (bus.host_correct ^ bus.host_wrong) begin
                        state_q         <= JUDGE;
                        locked_q        <= 1'b0;
                        judge_correct_q <= bus.host_correct;
                    end else if (bus.host_start && !bus.host_correct) begin
                        state_q  <= ARMED;
                        locked_q <= 1'b0;
                        armed_q  <= 1'b1;
                        timer_q  <= '0;
                    end
                end
                JUDGE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PLAYERS; i++) bank_q[i] <= '0;
        end else if (state_q == JUDGE) begin
            bank_q[player_q] <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) score_q <= '0;
        else     score_q <= bank_q[player_q];
    end

    assign bus.player       = player_q;
    assign bus.score        = score_q;
    assign bus.locked       = locked_q;
    assign bus.armed        = armed_q;
    assign bus.scan_restart = scan_restart_q;

endmodule

// File: tb/tb_answer_arbiter.sv
// Directed self-checking bench for answer_arbiter, built with a short arm timeout.
// Expected wrong-answer scores follow ANSWER_PENALTY_EN when the bench is built with it.
module tb_answer_arbiter;
    import answer_pkg::*;

    localparam int AWARD_T   = 10;
    localparam int PENALTY_T = 5;
    localparam int TIMEOUT_T = 20;

`ifdef ANSWER_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    answer_arbiter_if bus ();

    answer_arbiter #(
        .AWARD       (AWARD_T),
        .PENALTY     (PENALTY_T),
        .ARM_TIMEOUT (TIMEOUT_T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic [3:0] b, input logic s, input logic c, input logic w);
        bus.btn          = b;
        bus.host_start   = s;
        bus.host_correct = c;
        bus.host_wrong   = w;
        @(posedge clk);
        #1;
        bus.host_start   = 1'b0;
        bus.host_correct = 1'b0;
        bus.host_wrong   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic winRound(input int idx, input logic good, input int expScore);
        logic [3:0] b;
        b = 4'(1 << idx);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(b, 1'b0, 1'b0, 1'b0);
        applyStimulus(b, 1'b0, 1'b0, 1'b0);
        applyStimulus(b, 1'b0, 1'b0, 1'b0);
        applyStimulus(b, 1'b0, 1'b0, 1'b0);
        checkOutput("round_player", 32'(bus.player), 32'(idx));
        applyStimulus(4'b0000, 1'b0, good, !good);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("round_score", 32'(bus.score), 32'(expScore));
    endtask

    initial begin
        bus.btn          = 4'b0000;
        bus.host_start   = 1'b0;
        bus.host_correct = 1'b0;
        bus.host_wrong   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_player", 32'(bus.player), 0);
        checkOutput("reset_score", 32'(bus.score), 0);
        checkOutput("reset_locked", 32'(bus.locked), 0);
        checkOutput("reset_armed", 32'(bus.armed), 0);
        checkOutput("reset_scan", 32'(bus.scan_restart), 0);

        // Basic round on player 2 with latency checks.
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        checkOutput("arm_armed", 32'(bus.armed), 1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_k2_locked", 32'(bus.locked), 0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_k3_player", 32'(bus.player), 2);
        checkOutput("lat_k3_locked", 32'(bus.locked), 1);
        checkOutput("lat_k3_scan", 32'(bus.scan_restart), 1);
        checkOutput("lat_k3_armed", 32'(bus.armed), 0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_k4_scan", 32'(bus.scan_restart), 0);
        checkOutput("lat_k4_score", 32'(bus.score), 0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("judge_j_locked", 32'(bus.locked), 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("judge_j1_score", 32'(bus.score), 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("judge_j2_score", 32'(bus.score), 10);
        checkOutput("judge_idle_armed", 32'(bus.armed), 0);

        // Simultaneous rise on players 1 and 3; a later press by 3 is ignored.
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
        checkOutput("tie_player", 32'(bus.player), 1);
        checkOutput("tie_locked", 32'(bus.locked), 1);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("late_press_player", 32'(bus.player), 1);
        checkOutput("late_press_scan", 32'(bus.scan_restart), 0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("tie_score", 32'(bus.score), 10);

        // Abort from LOCKED, then let the re-armed round time out.
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_pre_locked", 32'(bus.locked), 1);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_locked", 32'(bus.locked), 0);
        checkOutput("abort_armed", 32'(bus.armed), 1);
        checkOutput("abort_player", 32'(bus.player), 2);
        repeat (TIMEOUT_T - 1) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_last_armed", 32'(bus.armed), 1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_armed", 32'(bus.armed), 0);
        checkOutput("abort_score", 32'(bus.score), 10);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        // Judgement outside LOCKED is ignored.
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_judge_score", 32'(bus.score), 10);

        // Player 3: wrong answers deduct and floor at zero only with the penalty enabled.
        winRound(3, 1'b1, 10);
        winRound(3, 1'b0, PEN ? 5 : 10);
        winRound(3, 1'b0, PEN ? 0 : 10);
        winRound(3, 1'b0, PEN ? 0 : 10);

        // Player 0 climbs to 90, then saturates at 99.
        for (int r = 1; r <= 9; r++) winRound(0, 1'b1, 10 * r);
        winRound(0, 1'b1, 99);
        winRound(0, 1'b1, 99);

        // Button held across arming does not lock; a fresh press does.
        repeat (4) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("held_locked", 32'(bus.locked), 0);
        checkOutput("held_armed", 32'(bus.armed), 1);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("repress_locked", 32'(bus.locked), 1);
        checkOutput("repress_player", 32'(bus.player), 0);

        // Both judge pulses together leave LOCKED and the score untouched.
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
        checkOutput("both_locked", 32'(bus.locked), 1);
        repeat (2) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("both_score", 32'(bus.score), 99);
        checkOutput("both_still_locked", 32'(bus.locked), 1);

        // Reset in LOCKED clears outputs and the bank.
        rst = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_locked", 32'(bus.locked), 0);
        checkOutput("rst_armed", 32'(bus.armed), 0);
        checkOutput("rst_score", 32'(bus.score), 0);
        checkOutput("rst_player", 32'(bus.player), 0);
        rst = 1'b0;
        repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_bank_cleared", 32'(bus.score), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/answer_arbiter.md
# answer_arbiter

Upstream stage of the display path in the multichannel answering machine. Arbitrates four player buttons, locks in the first valid press after the host arms a round, applies the host's correct/wrong judgement to a per-player score bank, and presents the winning player index and that player's score to the scan-tube display. Outputs are registered and stable between events, so the display can scan them freely.

## Interface
- `N_PLAYERS`, 4: number of buttons; fixed at 4 because `player` is 2 bits.
- `AWARD`, 10: points added on a correct answer.
- `PENALTY`, 5: points removed on a wrong answer (used only with `ANSWER_PENALTY_EN`).
- `ARM_TIMEOUT`, 50_000_000: cycles in ARMED with no press before the block returns to IDLE.
- `SCORE_MAX`, 99: saturation ceiling; the display shows two BCD digits.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in 4: raw player buttons, active-high, asynchronous to `clk`; bit i is player i.
- `host_start` in 1: one-cycle pulse that arms a round.
- `host_correct` in 1: one-cycle judgement pulse.
- `host_wrong` in 1: one-cycle judgement pulse.
- `player` out 2: index of the locked or last-locked player.
- `score` out 8: binary score of `player`, always ≤ `SCORE_MAX`.
- `locked` out 1: high while a press is awaiting judgement.
- `armed` out 1: high while in ARMED.
- `scan_restart` out 1: one-cycle pulse on each new lock; restarts the display animation.

## Operation
- Button front end:
  - Each `btn` bit passes through a 2-flop synchronizer, then a rising-edge detector, producing `rise[3:0]`.
  - A button already held when ARMED is entered does not count; only a rising edge counts.
- FSM states and transitions:
  - **IDLE**: `host_start` → ARMED.
  - **ARMED**:
    - any `rise` → LOCKED.
    - timeout counter reaches `ARM_TIMEOUT-1` → IDLE.
    - `host_start` → restarts the timeout and stays in ARMED.
  - **LOCKED**:
    - `host_correct` → JUDGE.
    - `host_wrong` → JUDGE.
    - `host_start` alone → ARMED (abort: no score change; `player` keeps its value).
  - **JUDGE**: lasts one cycle. The score bank writes, then the FSM goes to IDLE.
- Arbitration:
  - If several `rise` bits are set in the same cycle, the lowest index wins.
  - Presses outside ARMED are ignored.
- Score arithmetic (8-bit unsigned):
  - Correct: new = min(old + `AWARD`, `SCORE_MAX`). Compute in 9 bits before clamping.
  - Wrong: see Configuration.
- Simultaneous events and reset:
  - `host_correct` and `host_wrong` in the same cycle: both ignored; the FSM stays in LOCKED.
  - A judge pulse together with `host_start` in LOCKED: the judgement has priority.
  - Judge pulses outside LOCKED are ignored.
- `score` output:
  - Combinational mux of the bank by `player`, registered once.
  - It therefore follows a bank write or a `player` change one cycle later.

## Timing
- Reset values (bank scores too):
  - FSM IDLE; `player`=0, `score`=0, `locked`=0, `armed`=0, `scan_restart`=0.
  - All four bank scores = 0.
  - Synchronizers and timeout counter cleared.
- Reset asserted mid-round: everything returns to the reset values on the next edge. Scores are not retained.
- Button latency:
  - `btn` goes high before edge k.
  - `rise` is asserted at edge k+2.
  - At edge k+3: `player`, `locked`=1 and `scan_restart`=1 (for one cycle).
  - `score` is valid at edge k+4.
- Judge latency:
  - pulse sampled at edge j: JUDGE is entered and `locked`=0.
  - edge j+1: bank written and FSM in IDLE.
  - edge j+2: `score` shows the new value.
- `armed` is registered and equals (state==ARMED).
- Timeout counter:
  - 26-bit wide, cleared on entry to ARMED.
  - Never wraps: the exit condition fires first.

## Configuration
- `ANSWER_PENALTY_EN` defined:
  - wrong answer: new = (old < `PENALTY`) ? 0 : old − `PENALTY` (floors at 0).
- `ANSWER_PENALTY_EN` undefined:
  - wrong answer leaves the score unchanged.
  - the JUDGE cycle still occurs, so timing is identical.
  - `PENALTY` is unused.

## Structure
- Shared package `answer_pkg`:
  - state enum (IDLE, ARMED, LOCKED, JUDGE).
  - `SCORE_MAX`.
  - the `score_t` 8-bit type.
  - also used by the display path.
- Sub-module `btn_sync`:
  - one instance per button, generated for `N_PLAYERS`.
  - 2-flop synchronizer plus rising-edge detect.
  - ports `clk`, `rst`, `d`, `rise`.
- The score bank is held in the top level as a 4×8 register array with one write port.

## Test plan
- Reset, then `host_start`, then `btn`=0100 → at +3 cycles `player`=2, `locked`=1, one-cycle `scan_restart`; then `host_correct` → `score`=10 two cycles later; state IDLE.
- ARMED, `btn`=1010 rising in the same cycle → `player`=1. Player 3 is then ignored until the next round.
- Player 0 at score 95, correct → 99; correct again → 99 (saturation).
- Player 3 at score 3, `host_wrong` → 0 with `ANSWER_PENALTY_EN`, 3 without it. A second build covers both.
- `btn[0]` held high across `host_start` → no lock. Release and re-press → lock on player 0.
- Run with `ARM_TIMEOUT`=20:
  - no press → `armed` falls after 20 cycles.
  - `host_correct`+`host_wrong` together in LOCKED → no change.
  - `rst` pulse in LOCKED → all outputs 0.
